aesl_deadlock_detect_unit: RTL

AESL_DEADLOCK_DETECT_UNIT -- requirements
Module: aesl_deadlock_detect_unit

---
 rtl/aesl_deadlock_detect_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/aesl_deadlock_detect_unit.sv
// Per-process deadlock detection unit.
// Watches the monitored process's blocking pattern. Once that pattern has been
// stable long enough, the unit floods a dependency vector to the processes it
// waits on. It flags a deadlock when its own bit comes back around the cycle.
// After the global deadlock flag rises, it takes part in the token-passing
// report ring until the next reset.
module aesl_deadlock_detect_unit #(
    parameter int PROC_NUM      = 3,
    parameter int PROC_ID       = 0,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                         reset,
    input  logic                         clock,
    input  logic [PROC_NUM-1:0]          dep_vld,
    input  logic [PROC_NUM-1:0]          in_dep_vld,
    input  logic [PROC_NUM*PROC_NUM-1:0] in_dep_data,
    output logic [PROC_NUM-1:0]          out_dep_vld,
    output logic [PROC_NUM-1:0]          out_dep_data,
    input  logic [PROC_NUM-1:0]          token_in_vec,
    output logic [PROC_NUM-1:0]          token_out_vec,
    input  logic                         dl_detect_in,
    input  logic                         origin,
    input  logic                         token_clear,
    output logic                         dl_detect_out
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        BLOCKED,
        PROPAGATE,
        DETECTED,
        REPORT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PROC_NUM-1:0] dep_prev;
    logic [PROC_NUM-1:0] dep_reg;
    logic [PROC_NUM-1:0] dep_reg_next;
    logic [PROC_NUM-1:0] report_mask;
    logic [PROC_NUM-1:0] self_vec;
    logic [PROC_NUM-1:0] incoming;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic                originated;
    logic                forwarded;
    logic                self_hit;
    logic                pattern_stable;
    logic                pattern_changed;
    logic                sending_next;

    // Isolates the lowest set bit: the first process on the report path.
    function automatic logic [PROC_NUM-1:0] lowest_onehot(input logic [PROC_NUM-1:0] mask);
        return mask & (~mask + PROC_NUM'(1));
    endfunction

    // Merges every valid incoming dependency vector and checks for our own bit.
    always_comb begin
        self_vec           = '0;
        self_vec[PROC_ID]  = 1'b1;
        incoming           = '0;
        for (int j = 0; j < PROC_NUM; j++) begin
            if (in_dep_vld[j]) begin
                incoming = incoming | in_dep_data[j*PROC_NUM +: PROC_NUM];
            end
        end
        self_hit = incoming[PROC_ID];
    end

    // Stability counter: counts cycles of an unchanged, nonzero blocking pattern.
    always_comb begin
        pattern_stable  = (dep_vld != '0) && (dep_vld == dep_prev);
        pattern_changed = (dep_vld != '0) && (dep_vld != dep_prev);
        if (!pattern_stable) begin
            cnt_next = '0;
        end else if (cnt == CNT_MAX) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // Next-state and dependency-vector selection; the global flag overrides all.
    always_comb begin
        state_next   = state;
        dep_reg_next = dep_reg;
        if (dl_detect_in || state == REPORT) begin
            state_next = REPORT;
        end else begin
            case (state)
                IDLE: begin
                    if (dep_vld != '0) begin
                        state_next = BLOCKED;
                    end
                end
                BLOCKED: begin
                    if (dep_vld == '0) begin
                        state_next   = IDLE;
                        dep_reg_next = '0;
                    end else if (pattern_changed) begin
                        state_next   = BLOCKED;
                        dep_reg_next = '0;
                    end else if (cnt_next == CNT_MAX) begin
                        state_next   = PROPAGATE;
                        dep_reg_next = self_vec | incoming;
                    end
                end
                PROPAGATE: begin
                    if (dep_vld == '0) begin
                        state_next   = IDLE;
                        dep_reg_next = '0;
                    end else if (pattern_changed) begin
                        state_next   = BLOCKED;
                        dep_reg_next = '0;
                    end else begin
                        dep_reg_next = self_vec | incoming;
                        if (self_hit) begin
                            state_next = DETECTED;
                        end
                    end
                end
                DETECTED: begin
                    if (dep_vld == '0) begin
                        state_next   = IDLE;
                        dep_reg_next = '0;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    dep_reg_next = '0;
                end
            endcase
        end
        sending_next = (state_next == PROPAGATE) || (state_next == DETECTED);
    end

    // State, history and registered outputs, including the report token ring.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            dep_prev      <= '0;
            cnt           <= '0;
            dep_reg       <= '0;
            report_mask   <= '0;
            originated    <= 1'b0;
            forwarded     <= 1'b0;
            out_dep_vld   <= '0;
            out_dep_data  <= '0;
            token_out_vec <= '0;
            dl_detect_out <= 1'b0;
        end else begin
            state        <= state_next;
            dep_prev     <= dep_vld;
            cnt          <= cnt_next;
            dep_reg      <= dep_reg_next;
            out_dep_vld  <= sending_next ? dep_vld : '0;
            out_dep_data <= sending_next ? dep_reg_next : '0;
            // First-detection indication; the global flag is low whenever DETECTED is next.
            dl_detect_out <= (state_next == DETECTED);

            // Snapshot the blocking pattern once, on the way into REPORT.
            if (state != REPORT && state_next == REPORT) begin
                report_mask <= dep_prev;
            end

            if (state == REPORT) begin
                // Clear beats origin, origin beats an arriving token.
                if (token_clear) begin
                    token_out_vec <= '0;
                    originated    <= 1'b0;
                    forwarded     <= 1'b0;
                end else if (origin) begin
                    token_out_vec <= lowest_onehot(report_mask);
                    originated    <= 1'b1;
                end else if ((|token_in_vec) && !forwarded) begin
                    dl_detect_out <= 1'b1;
                    // The originator closes the ring instead of passing it on.
                    if (!originated) begin
                        token_out_vec <= lowest_onehot(report_mask);
                        forwarded     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
